std_pipe_regslice: RTL
======================

Name: std_pipe_regslice

Overview:
Parametrised, multi-stage register slice with valid/ready handshake. It is the handshaked successor of the plain resettable DFF.
- DEPTH chained full-throughput stages. Each stage has a main register and a skid register.
- No combinational path from m_ready to s_ready.
- Used to cut timing paths on handshaked buses between pipeline units. Adds a synchronous flush for pipeline kill.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
DEPTH, 2, number of register-slice stages (>=1); elaboration error if 0
RESET_VALUE, {DATA_WIDTH{1'b0}}, value loaded into every data register on reset/flush

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of all buffered beats
s_valid  input  1  upstream beat valid
s_ready  output  1  slice can accept a beat; registered
s_data  input  DATA_WIDTH  upstream payload
m_valid  output  1  downstream beat valid; registered
m_ready  input  1  downstream accepts
m_data  output  DATA_WIDTH  downstream payload; registered

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Handshake: a transfer occurs on a cycle with valid&ready high at posedge.
  - Once asserted, m_valid is held and m_data is stable until m_ready.
  - Upstream obeys the same rule. The bench checks it; the RTL does not enforce it.
- Per-stage state machine. State is one of EMPTY, HALF (main occupied), FULL (main+skid occupied). in_fire = in_valid&in_ready; out_fire = out_valid&out_ready.
  - EMPTY: in_fire -> HALF, main<=in.
  - HALF, in_fire only -> FULL, skid<=in.
  - HALF, out_fire only -> EMPTY.
  - HALF, both fire -> HALF, main<=in.
  - FULL: out_fire -> HALF, main<=skid. in_ready=0, so no in_fire is possible.
  - Stage outputs: in_ready = (state!=FULL); out_valid = (state!=EMPTY); out_data = main.
- Chaining: stage i output feeds stage i+1 input.
  - s_* connects to stage 0; m_* connects to stage DEPTH-1.
- Latency: a beat accepted at posedge t is presented on m_data at posedge t+DEPTH when there is no backpressure.
- Throughput: 1 beat/cycle sustained.
- Capacity: 2*DEPTH beats. Ordering is strict FIFO and no beat is ever duplicated or dropped, except by flush/reset.
- Reset (highest priority):
  - All stages go to EMPTY; main and skid registers load RESET_VALUE.
  - Next cycle: m_valid=0, m_data=RESET_VALUE, s_ready=1.
- Flush (below reset):
  - Same register effect as reset.
  - An m-side transfer in the flush cycle completes normally.
  - An s-side beat handshaked in the flush cycle is discarded.
- Simultaneous reset+flush: behaves as reset.
- Reset mid-transfer: any in-flight beat is lost; no partial state survives.
- Backpressure: with m_ready=0, s_ready drops one cycle after the slice holds 2*DEPTH beats.

Optional Feature:
Macro STD_PIPE_REGSLICE_OCCUPANCY_EN.
- Defined: adds output port occupancy, width $clog2(2*DEPTH+1).
  - Registered count of buffered beats: +1 on s-fire, -1 on m-fire, unchanged on both.
  - Cleared to 0 by reset/flush (s-fire in the flush cycle is not counted).
  - Also adds a simulation-only assertion that occupancy never exceeds 2*DEPTH.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package std_pipe_pkg holds:
  - the stage-state localparams/typedef (EMPTY=2'd0, HALF=2'd1, FULL=2'd2);
  - the function computing occupancy width.
- Sub-module std_regslice_stage: one stage (state FSM + main/skid registers). It has parameters DATA_WIDTH and RESET_VALUE and the same reset/flush ports.
- Top level is a generate loop of DEPTH instances plus the optional occupancy counter.

Test Plan:
- DEPTH=2, m_ready=1, stream 0x1..0x8 back-to-back -> m_data 0x1..0x8 in order, first at cycle +2, one per cycle, s_ready constantly 1.
- DEPTH=2, m_ready=0, push until s_ready=0 -> exactly 4 beats accepted; s_ready low the cycle after the 4th. Release m_ready -> 4 beats out in order, s_ready high again one cycle after the first m-fire.
- Random valid/ready toggling, 10k beats, DEPTH=1 and 3 -> scoreboard exact in-order match; m_data stable while m_valid&!m_ready.
- 3 beats buffered, flush with m_valid&m_ready and s_valid high -> head beat delivered, s beat dropped. Next cycle m_valid=0, m_data=RESET_VALUE, s_ready=1.
- Assert reset mid-stream (DEPTH=2, RESET_VALUE=0xA5) -> next cycle m_valid=0, m_data=0xA5, s_ready=1; reset+flush together is identical.
- With STD_PIPE_REGSLICE_OCCUPANCY_EN, DEPTH=2: 4 pushes with m_ready=0 -> occupancy 1,2,3,4. Simultaneous push+pop holds 4→3 path correctly; flush -> 0.

Source files
------------

// File: rtl/std_pipe_pkg.sv
// Shared types for the handshaked register slice: per-stage state encoding
// and the occupancy counter width helper.
package std_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    // Enough bits to count 0 .. 2*depth buffered beats.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/std_regslice_stage.sv
// One full-throughput register slice stage: main + skid register, 3-state FSM.
// Ports: clk, reset, flush; in_valid/in_ready/in_data; out_valid/out_ready/out_data.
module std_regslice_stage
    import std_pipe_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    stage_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_fire, out_fire;

    // in_ready comes only from local state, so downstream ready never
    // reaches upstream combinationally.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = HALF;
                    main_d  = in_data;
                end
            end
            HALF: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = HALF;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Flush has the same register effect as reset; an input beat
    // handshaked in that cycle is simply not captured.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/std_pipe_regslice.sv
// DEPTH chained register slice stages with valid/ready handshake and flush.
// Ports: clk, reset, flush; s_valid/s_ready/s_data; m_valid/m_ready/m_data.
// Define STD_PIPE_REGSLICE_OCCUPANCY_EN to add the occupancy output port.
module std_pipe_regslice
    import std_pipe_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           DEPTH       = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef STD_PIPE_REGSLICE_OCCUPANCY_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("std_pipe_regslice: DEPTH must be >= 1");
    end

    // Link i is the input of stage i; link DEPTH is the m-side.
    logic [DEPTH:0]        vld;
    logic [DEPTH:0]        rdy;
    logic [DATA_WIDTH-1:0] dat [DEPTH+1];

    assign vld[0]     = s_valid;
    assign dat[0]     = s_data;
    assign s_ready    = rdy[0];
    assign m_valid    = vld[DEPTH];
    assign m_data     = dat[DEPTH];
    assign rdy[DEPTH] = m_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        std_regslice_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (vld[i]),
            .in_ready  (rdy[i]),
            .in_data   (dat[i]),
            .out_valid (vld[i+1]),
            .out_ready (rdy[i+1]),
            .out_data  (dat[i+1])
        );
    end

`ifdef STD_PIPE_REGSLICE_OCCUPANCY_EN
    localparam int unsigned OW = occ_width(DEPTH);
    localparam logic [OW-1:0] OCC_MAX = OW'(2 * DEPTH);

    logic s_fire, m_fire;

    assign s_fire = s_valid & s_ready;
    assign m_fire = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else if (s_fire && !m_fire) begin
            occupancy <= occupancy + 1'b1;
        end else if (!s_fire && m_fire) begin
            occupancy <= occupancy - 1'b1;
        end
    end

    a_occ_max : assert property (
        @(posedge clk) disable iff (reset) occupancy <= OCC_MAX
    );
`endif

endmodule
